// File: rtl/crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : crossing_scheduler
//  Description : Round-robin scheduler for a shared pedestrian crossing.
//                Three request buttons are latched into a pending vector;
//                one owner at a time is granted a crossing made of a single
//                START pulse cycle, CROSS_CYCLES cycles of CROSS and
//                MIN_GAP cycles of GAP before the next crossing can launch.
//
//  Ports       : clock     - single clock, rising edge
//                reset     - synchronous active-high reset
//                req[2:0]  - request buttons, bit i = requester i
//                emergency - override input (XSCHED_EMERGENCY_EN only)
//                start     - one-cycle launch pulse
//                grant[2:0]- one-hot owner of current crossing, 0 if none
//                pending   - latched requests not yet served
//                busy      - high whenever the scheduler is not idle
//
//  Option      : define XSCHED_EMERGENCY_EN to add the emergency input and
//                the HOLD state (abort crossing, resume via GAP).
//
//  Revision    : 1.0  initial release
// ============================================================================
module crossing_scheduler #(
    parameter int unsigned CROSS_CYCLES = 10,
    parameter int unsigned MIN_GAP      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
`ifdef XSCHED_EMERGENCY_EN
    input  logic       emergency,
`endif
    output logic       start,
    output logic [2:0] grant,
    output logic [2:0] pending,
    output logic       busy
);

    localparam logic [7:0] c_CROSS_LAST = 8'(CROSS_CYCLES - 1);
    localparam logic [7:0] c_GAP_LAST   = 8'(MIN_GAP - 1);

`ifdef XSCHED_EMERGENCY_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CROSS = 3'd2,
        S_GAP   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CROSS = 2'd2,
        S_GAP   = 2'd3
    } state_t;
`endif

    state_t     r_state;
    logic [2:0] r_pending;
    logic [2:0] r_grant;
    logic       r_start;
    logic       r_busy;
    logic       r_arm;
    logic [1:0] r_rr_ptr;
    logic [7:0] r_cross_cnt;
    logic [7:0] r_gap_cnt;

    logic [2:0] w_pend_set;
    logic [1:0] w_win_idx;
    logic [2:0] w_win_oh;
    logic [1:0] w_next_ptr;

    // First set bit among (a, b, c) in that search order.
    function automatic logic [1:0] f_first(input logic [2:0] p,
                                           input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic [1:0] c);
        if (p[a]) begin
            return a;
        end else if (p[b]) begin
            return b;
        end else begin
            return c;
        end
    endfunction

    assign w_pend_set = r_pending | req;

    // Round-robin search starting at r_rr_ptr, wrapping modulo 3.
    always_comb begin
        w_win_idx = 2'd0;
        case (r_rr_ptr)
            2'd1:    w_win_idx = f_first(r_pending, 2'd1, 2'd2, 2'd0);
            2'd2:    w_win_idx = f_first(r_pending, 2'd2, 2'd0, 2'd1);
            default: w_win_idx = f_first(r_pending, 2'd0, 2'd1, 2'd2);
        endcase
        w_win_oh   = 3'b001 << w_win_idx;
        w_next_ptr = (w_win_idx == 2'd2) ? 2'd0 : (w_win_idx + 2'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= 3'b000;
            r_grant     <= 3'b000;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_arm       <= 1'b0;
            r_rr_ptr    <= 2'd0;
            r_cross_cnt <= 8'd0;
            r_gap_cnt   <= 8'd0;
        end else begin
            r_pending <= w_pend_set;
            r_start   <= 1'b0;
            r_arm     <= 1'b0;
`ifdef XSCHED_EMERGENCY_EN
            if (emergency) begin
                // Abort whatever is in progress; pending and rr_ptr survive.
                r_state     <= S_HOLD;
                r_grant     <= 3'b000;
                r_busy      <= 1'b1;
                r_cross_cnt <= 8'd0;
                r_gap_cnt   <= 8'd0;
            end else begin
`else
            begin
`endif
                case (r_state)
                    S_IDLE: begin
                        // One qualifying idle cycle with requests waiting
                        // arms the launch; the crossing starts on the next edge.
                        if (r_arm) begin
                            r_state   <= S_START;
                            r_start   <= 1'b1;
                            r_grant   <= w_win_oh;
                            r_busy    <= 1'b1;
                            r_rr_ptr  <= w_next_ptr;
                            // Clearing the winner beats a simultaneous press.
                            r_pending <= w_pend_set & ~w_win_oh;
                        end else begin
                            r_arm <= |r_pending;
                        end
                    end
                    S_START: begin
                        r_state     <= S_CROSS;
                        r_cross_cnt <= 8'd0;
                    end
                    S_CROSS: begin
                        if (r_cross_cnt == c_CROSS_LAST) begin
                            r_state   <= S_GAP;
                            r_grant   <= 3'b000;
                            r_gap_cnt <= 8'd0;
                        end else begin
                            r_cross_cnt <= r_cross_cnt + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == c_GAP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                    end
`ifdef XSCHED_EMERGENCY_EN
                    S_HOLD: begin
                        // Emergency has cleared: always pass through a full gap.
                        r_state   <= S_GAP;
                        r_gap_cnt <= 8'd0;
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_grant <= 3'b000;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start   = r_start;
    assign grant   = r_grant;
    assign pending = r_pending;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossing_scheduler
//  Description : Directed self-checking bench for crossing_scheduler. A
//                timeline model (age since launch, idle readiness, hold flag)
//                predicts outputs every cycle; literal checks pin key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crossing_scheduler;

    localparam int C = 10;
    localparam int G = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req   = 3'b000;
`ifdef XSCHED_EMERGENCY_EN
    logic       emergency = 1'b0;
`endif
    logic       start;
    logic       busy;
    logic [2:0] grant;
    logic [2:0] pending;

    crossing_scheduler #(
        .CROSS_CYCLES(C),
        .MIN_GAP     (G)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
`ifdef XSCHED_EMERGENCY_EN
        .emergency(emergency),
`endif
        .start    (start),
        .grant    (grant),
        .pending  (pending),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: m_age is the number of edges since the launch edge
    // (-1 when no crossing is in progress). Age 0 = start pulse, ages
    // 1..C = crossing, C+1..C+G = gap. A launch happens on the edge after
    // an idle edge that already saw requests waiting.
    // ------------------------------------------------------------------
    int         cyc     = 0;
    int         m_age   = -1;
    int         m_ptr   = 0;
    int         m_owner = 0;
    bit         m_hold  = 1'b0;
    bit         m_ready = 1'b0;
    bit         m_valid = 1'b0;
    logic [2:0] m_pend  = 3'b000;

    always @(posedge clock) begin
        logic [2:0] np;
        logic [2:0] oh;
        bit         e;
        int         w;
        cyc = cyc + 1;
`ifdef XSCHED_EMERGENCY_EN
        e = emergency;
`else
        e = 1'b0;
`endif
        if (reset) begin
            m_valid = 1'b1;
            m_pend  = 3'b000;
            m_ptr   = 0;
            m_age   = -1;
            m_ready = 1'b0;
            m_hold  = 1'b0;
            m_owner = 0;
        end else if (m_valid) begin
            np = m_pend | req;
            if (e) begin
                m_hold  = 1'b1;
                m_age   = -1;
                m_ready = 1'b0;
                m_pend  = np;
            end else if (m_hold) begin
                m_hold = 1'b0;
                m_age  = C + 1;
                m_pend = np;
            end else if (m_age >= 0) begin
                m_age = m_age + 1;
                if (m_age > C + G) m_age = -1;
                m_ready = 1'b0;
                m_pend  = np;
            end else if (m_ready) begin
                w = -1;
                for (int s = 0; s < 3; s++) begin
                    if (w < 0 && m_pend[(m_ptr + s) % 3]) w = (m_ptr + s) % 3;
                end
                oh      = 3'(1 << w);
                m_owner = w;
                m_ptr   = (w + 1) % 3;
                m_age   = 0;
                m_ready = 1'b0;
                m_pend  = np & ~oh;
            end else begin
                m_ready = (m_pend != 3'b000);
                m_pend  = np;
            end
        end
    end

    // Launch log (grant and cycle of each start pulse) for literal checks.
    bit         log_en = 1'b0;
    logic [2:0] lg[$];
    int         lt[$];

    always @(negedge clock) begin
        logic [2:0] exp_grant;
        if (m_valid) begin
            exp_grant = (m_age >= 0 && m_age <= C) ? 3'(1 << m_owner) : 3'b000;
            check("start",   int'(start),   int'(m_age == 0));
            check("grant",   int'(grant),   int'(exp_grant));
            check("pending", int'(pending), int'(m_pend));
            check("busy",    int'(busy),    int'(m_hold || m_age >= 0));
            if (log_en && start) begin
                lg.push_back(grant);
                lt.push_back(cyc);
            end
        end
    end

    task automatic drive(input logic r, input logic [2:0] q, input logic e, input int n);
        repeat (n) begin
            @(negedge clock);
            reset = r;
            req   = q;
`ifdef XSCHED_EMERGENCY_EN
            emergency = e;
`endif
            @(posedge clock);
        end
        #1;
    endtask

    function automatic int lgv(input int i);
        return (lg.size() > i) ? int'(lg[i]) : 7;
    endfunction

    function automatic int ltd(input int i);
        return (lt.size() > i + 1) ? (lt[i + 1] - lt[i]) : -1;
    endfunction

    initial begin
        // Reset state
        drive(1'b1, 3'b000, 1'b0, 3);
        check("rst_start",   int'(start),   0);
        check("rst_grant",   int'(grant),   0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy",    int'(busy),    0);

        // Single request, full crossing timeline
        drive(1'b0, 3'b010, 1'b0, 1);
        check("one_pend_latched", int'(pending), 3'b010);
        check("one_no_start_yet", int'(start),   0);
        drive(1'b0, 3'b000, 1'b0, 1);
        check("one_wait_cycle",   int'(start),   0);
        drive(1'b0, 3'b000, 1'b0, 1);
        check("one_start",        int'(start),   1);
        check("one_grant",        int'(grant),   3'b010);
        check("one_pend_clear",   int'(pending), 0);
        drive(1'b0, 3'b000, 1'b0, 10);
        check("one_cross_last",   int'(grant),   3'b010);
        drive(1'b0, 3'b000, 1'b0, 1);
        check("one_gap_grant",    int'(grant),   0);
        check("one_gap_busy",     int'(busy),    1);
        drive(1'b0, 3'b000, 1'b0, 4);
        check("one_idle_busy",    int'(busy),    0);

        // All three at once from reset: 001, 010, 100
        drive(1'b1, 3'b000, 1'b0, 2);
        lg.delete(); lt.delete(); log_en = 1'b1;
        drive(1'b0, 3'b111, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 60);
        log_en = 1'b0;
        check("all_count",  lg.size(), 3);
        check("all_first",  lgv(0), 3'b001);
        check("all_second", lgv(1), 3'b010);
        check("all_third",  lgv(2), 3'b100);
        check("all_spacing", ltd(0), 17);

        // Late arrivals during bit 1's crossing honour rr_ptr=2
        drive(1'b1, 3'b000, 1'b0, 2);
        lg.delete(); lt.delete(); log_en = 1'b1;
        drive(1'b0, 3'b011, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 22);
        check("rr_bit1_crossing", int'(grant), 3'b010);
        drive(1'b0, 3'b101, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 60);
        log_en = 1'b0;
        check("rr_count", lg.size(), 4);
        check("rr_g0", lgv(0), 3'b001);
        check("rr_g1", lgv(1), 3'b010);
        check("rr_g2", lgv(2), 3'b100);
        check("rr_g3", lgv(3), 3'b001);

        // Held button: crossings every 17 cycles
        drive(1'b1, 3'b000, 1'b0, 2);
        lg.delete(); lt.delete(); log_en = 1'b1;
        drive(1'b0, 3'b001, 1'b0, 60);
        log_en = 1'b0;
        check("held_count",  lg.size(), 4);
        check("held_period0", ltd(0), 17);
        check("held_period1", ltd(1), 17);
        check("held_period2", ltd(2), 17);
        drive(1'b0, 3'b000, 1'b0, 40);

        // Reset on the 5th crossing cycle, with requests on the reset edge
        drive(1'b1, 3'b000, 1'b0, 2);
        drive(1'b0, 3'b010, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 2);
        check("mid_start", int'(start), 1);
        drive(1'b0, 3'b000, 1'b0, 5);
        check("mid_cross", int'(grant), 3'b010);
        drive(1'b1, 3'b111, 1'b0, 1);
        check("mid_rst_grant",   int'(grant),   0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_busy",    int'(busy),    0);
        check("mid_rst_start",   int'(start),   0);
        drive(1'b0, 3'b000, 1'b0, 3);
        check("mid_after_busy",  int'(busy),    0);

`ifdef XSCHED_EMERGENCY_EN
        // Emergency on the 3rd crossing cycle for 6 edges
        drive(1'b1, 3'b000, 1'b0, 2);
        drive(1'b0, 3'b001, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 2);
        drive(1'b0, 3'b000, 1'b0, 2);
        drive(1'b0, 3'b000, 1'b1, 1);
        check("em_grant", int'(grant), 0);
        check("em_busy",  int'(busy),  1);
        drive(1'b0, 3'b010, 1'b1, 1);
        drive(1'b0, 3'b000, 1'b1, 4);
        check("em_hold_pending", int'(pending), 3'b010);
        drive(1'b0, 3'b000, 1'b0, 1);
        check("em_gap_busy", int'(busy), 1);
        drive(1'b0, 3'b000, 1'b0, 4);
        check("em_idle_busy", int'(busy), 0);
        drive(1'b0, 3'b000, 1'b0, 2);
        check("em_served_start", int'(start), 1);
        check("em_served_grant", int'(grant), 3'b010);
        drive(1'b0, 3'b000, 1'b0, 20);
`endif

        // Mixed late traffic, checked by the model only
        drive(1'b0, 3'b110, 1'b0, 1);
        drive(1'b0, 3'b000, 1'b0, 5);
        drive(1'b0, 3'b001, 1'b0, 3);
        drive(1'b0, 3'b000, 1'b0, 12);
        drive(1'b0, 3'b100, 1'b0, 2);
        drive(1'b0, 3'b000, 1'b0, 70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
